// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle: hazard observations from the pipeline registers in,
// stall/bubble controls, halted flag and performance counters out.
interface pipe_ctrl_if;
  logic [3:0]  D_icode;
  logic [3:0]  d_srcA;
  logic [3:0]  d_srcB;
  logic [3:0]  E_icode;
  logic [3:0]  E_dstM;
  logic        e_Cnd;
  logic [3:0]  M_icode;
  logic [2:0]  m_stat;
  logic [3:0]  W_icode;
  logic [2:0]  W_stat;

  logic        F_stall;
  logic        D_stall;
  logic        D_bubble;
  logic        E_bubble;
  logic        M_bubble;
  logic        W_stall;
  logic        set_cc;

  logic        halted;
  logic [31:0] cycle_cnt;
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;
  logic [31:0] retire_cnt;

  // No handshake: every signal is a level that is valid each cycle; the
  // controller answers combinationally in the same cycle it sees the inputs.
  modport master (
    output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
           M_icode, m_stat, W_icode, W_stat,
    input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc,
           halted, cycle_cnt, stall_cnt, bubble_cnt, retire_cnt
  );

  modport slave (
    input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
           M_icode, m_stat, W_icode, W_stat,
    output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc,
           halted, cycle_cnt, stall_cnt, bubble_cnt, retire_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Y86-style pipeline hazard controller: load/use, ret and mispredict handling,
// exception drain/halt FSM and free-running performance counters.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus,
  output logic [1:0]  state_o
);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] RNONE    = 4'hF;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0] cycle_cnt_q,  cycle_cnt_d;
  logic [31:0] stall_cnt_q,  stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;

  logic load_use;
  logic ret_pend;
  logic mispred;
  logic exc_m;
  logic exc_w;
  logic halt_edge;

  logic f_stall;
  logic d_stall;
  logic d_bubble;
  logic e_bubble;
  logic m_bubble;
  logic w_stall;
  logic cc_en;

  // Hazard detection
  always_comb begin
    load_use = ((bus.E_icode == I_MRMOVQ) || (bus.E_icode == I_POPQ)) &&
               (bus.E_dstM != RNONE) &&
               ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
    ret_pend = (bus.D_icode == I_RET) || (bus.E_icode == I_RET) ||
               (bus.M_icode == I_RET);
    mispred  = (bus.E_icode == I_JXX) && !bus.e_Cnd;
    exc_m    = (bus.m_stat == S_ADR) || (bus.m_stat == S_INS) ||
               (bus.m_stat == S_HLT);
    exc_w    = (bus.W_stat == S_ADR) || (bus.W_stat == S_INS) ||
               (bus.W_stat == S_HLT);
  end

  // State transitions; exc_w beats exc_m when both arrive together
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (exc_w)      state_d = ST_HALTED;
        else if (exc_m) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (exc_w)       state_d = ST_HALTED;
        else if (!exc_m) state_d = ST_RUN;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  // Control outputs. load_use owns D when it collides with a pending ret.
  always_comb begin
    f_stall  = 1'b0;
    d_stall  = 1'b0;
    d_bubble = 1'b0;
    e_bubble = 1'b0;
    m_bubble = 1'b0;
    w_stall  = 1'b0;
    cc_en    = 1'b0;
    if (rst) begin
      f_stall = 1'b0;
    end else if (state_q == ST_HALTED) begin
      f_stall  = 1'b1;
      d_stall  = 1'b1;
      w_stall  = 1'b1;
      m_bubble = 1'b1;
    end else begin
      f_stall  = load_use | ret_pend;
      d_stall  = load_use;
      d_bubble = mispred | (ret_pend & !load_use);
      e_bubble = mispred | load_use;
      m_bubble = exc_m | exc_w;
      w_stall  = exc_w;
      cc_en    = (bus.E_icode == I_OPQ) & !exc_m & !exc_w;
    end
  end

  assign halt_edge = (state_q != ST_HALTED) && (state_d == ST_HALTED);

  // Counters only move outside HALTED; the halting HLT instruction retires once.
  always_comb begin
    cycle_cnt_d  = cycle_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    retire_cnt_d = retire_cnt_q;
    if (state_q != ST_HALTED) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
      if (d_stall)
        stall_cnt_d = stall_cnt_q + 32'd1;
      if (d_bubble || e_bubble)
        bubble_cnt_d = bubble_cnt_q + 32'd1;
      if (((bus.W_stat == S_AOK) && (bus.W_icode != I_NOP)) ||
          (halt_edge && (bus.W_stat == S_HLT)))
        retire_cnt_d = retire_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      cycle_cnt_q  <= 32'd0;
      stall_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
      retire_cnt_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      cycle_cnt_q  <= cycle_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign bus.F_stall    = f_stall;
  assign bus.D_stall    = d_stall;
  assign bus.D_bubble   = d_bubble;
  assign bus.E_bubble   = e_bubble;
  assign bus.M_bubble   = m_bubble;
  assign bus.W_stall    = w_stall;
  assign bus.set_cc     = cc_en;
  assign bus.halted     = (state_q == ST_HALTED) && !rst;
  assign bus.cycle_cnt  = cycle_cnt_q;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.bubble_cnt = bubble_cnt_q;
  assign bus.retire_cnt = retire_cnt_q;
  assign state_o        = state_q;

  // HALT icode is decoded upstream; referenced here only to keep the encoding table complete.
  logic unused_halt_code;
  assign unused_halt_code = ^I_HALT;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazard vectors, drain/halt sequence, reset
// recovery, with hand-computed control values and counter deltas.
module tb_pipe_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] state_o;

  pipe_ctrl_if bus ();

  pipe_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .state_o (state_o)
  );

  int n_checks;
  int n_errors;
  int exp_cyc;
  int exp_stall;
  int exp_bub;
  int exp_ret;

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_ctrl(input string tag, input logic f, input logic ds, input logic db,
                            input logic eb, input logic mb, input logic ws, input logic sc);
    check({tag, ".F_stall"},  {31'd0, bus.F_stall},  {31'd0, f});
    check({tag, ".D_stall"},  {31'd0, bus.D_stall},  {31'd0, ds});
    check({tag, ".D_bubble"}, {31'd0, bus.D_bubble}, {31'd0, db});
    check({tag, ".E_bubble"}, {31'd0, bus.E_bubble}, {31'd0, eb});
    check({tag, ".M_bubble"}, {31'd0, bus.M_bubble}, {31'd0, mb});
    check({tag, ".W_stall"},  {31'd0, bus.W_stall},  {31'd0, ws});
    check({tag, ".set_cc"},   {31'd0, bus.set_cc},   {31'd0, sc});
  endtask

  task automatic set_idle();
    bus.D_icode = 4'h1;
    bus.d_srcA  = 4'hF;
    bus.d_srcB  = 4'hF;
    bus.E_icode = 4'h1;
    bus.E_dstM  = 4'hF;
    bus.e_Cnd   = 1'b1;
    bus.M_icode = 4'h1;
    bus.m_stat  = 3'd1;
    bus.W_icode = 4'h1;
    bus.W_stat  = 3'd1;
  endtask

  // One clock edge, then compare counters against the hand-given deltas
  task automatic tick(input int dc, input int ds, input int db, input int dr);
    @(posedge clk);
    @(negedge clk);
    exp_cyc   += dc;
    exp_stall += ds;
    exp_bub   += db;
    exp_ret   += dr;
    check("cycle_cnt",  bus.cycle_cnt,  exp_cyc);
    check("stall_cnt",  bus.stall_cnt,  exp_stall);
    check("bubble_cnt", bus.bubble_cnt, exp_bub);
    check("retire_cnt", bus.retire_cnt, exp_ret);
  endtask

  task automatic check_state(input string tag, input logic [1:0] st, input logic h);
    check({tag, ".state"},  {30'd0, state_o},    {30'd0, st});
    check({tag, ".halted"}, {31'd0, bus.halted}, {31'd0, h});
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    exp_cyc = 0; exp_stall = 0; exp_bub = 0; exp_ret = 0;

    // reset with a load-use pattern on the inputs: outputs must stay 0
    rst = 1'b1;
    set_idle();
    bus.E_icode = 4'h5; bus.E_dstM = 4'h3; bus.d_srcA = 4'h3;
    @(posedge clk);
    @(negedge clk);
    #1;
    check_ctrl("reset", 0, 0, 0, 0, 0, 0, 0);
    check_state("reset", 2'd0, 1'b0);
    check("reset.cycle_cnt", bus.cycle_cnt, 32'd0);
    check("reset.retire_cnt", bus.retire_cnt, 32'd0);

    set_idle();
    rst = 1'b0;
    #1;
    check_ctrl("idle", 0, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0);

    // load-use
    bus.E_icode = 4'h5; bus.E_dstM = 4'h3; bus.d_srcA = 4'h3;
    #1;
    check_ctrl("load_use", 1, 1, 0, 1, 0, 0, 0);
    tick(1, 1, 1, 0);

    // mispredict: bubble counted once
    set_idle();
    bus.E_icode = 4'h7; bus.e_Cnd = 1'b0;
    #1;
    check_ctrl("mispred", 0, 0, 1, 1, 0, 0, 0);
    tick(1, 0, 1, 0);

    // taken jump: no hazard
    bus.e_Cnd = 1'b1;
    #1;
    check_ctrl("jxx_taken", 0, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0);

    // ret walking D -> E -> M
    set_idle();
    bus.D_icode = 4'h9;
    #1;
    check_ctrl("ret_D", 1, 0, 1, 0, 0, 0, 0);
    tick(1, 0, 1, 0);
    bus.D_icode = 4'h1; bus.E_icode = 4'h9;
    #1;
    check_ctrl("ret_E", 1, 0, 1, 0, 0, 0, 0);
    tick(1, 0, 1, 0);
    bus.E_icode = 4'h1; bus.M_icode = 4'h9;
    #1;
    check_ctrl("ret_M", 1, 0, 1, 0, 0, 0, 0);
    tick(1, 0, 1, 0);
    set_idle();
    #1;
    check_ctrl("ret_done", 0, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0);

    // ret + load-use: load-use has priority over D
    bus.D_icode = 4'h9; bus.E_icode = 4'hB; bus.E_dstM = 4'h4; bus.d_srcB = 4'h4;
    #1;
    check_ctrl("ret_load_use", 1, 1, 0, 1, 0, 0, 0);
    tick(1, 1, 1, 0);

    // E_dstM == RNONE never forms a load-use even if a source is RNONE
    set_idle();
    bus.E_icode = 4'h5; bus.E_dstM = 4'hF; bus.d_srcA = 4'hF;
    #1;
    check_ctrl("rnone", 0, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0);

    // OPq sets CC; an OPq in W retires
    set_idle();
    bus.E_icode = 4'h6; bus.W_icode = 4'h6;
    #1;
    check_ctrl("opq", 0, 0, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 1);

    // drain and recover (mispredict squashed the faulting instruction)
    set_idle();
    bus.m_stat = 3'd3; bus.E_icode = 4'h6;
    #1;
    check_ctrl("exc_m", 0, 0, 0, 0, 1, 0, 0);
    tick(1, 0, 0, 0);
    check_state("drain", 2'd1, 1'b0);
    set_idle();
    bus.E_icode = 4'h7; bus.e_Cnd = 1'b0;
    #1;
    check_ctrl("drain_mispred", 0, 0, 1, 1, 0, 0, 0);
    tick(1, 0, 1, 0);
    check_state("drain_back", 2'd0, 1'b0);

    // idle up to cycle 98
    set_idle();
    while (exp_cyc < 98) tick(1, 0, 0, 0);

    // halt sequence
    bus.m_stat = 3'd2; bus.E_icode = 4'h6;
    #1;
    check_ctrl("halt_m", 0, 0, 0, 0, 1, 0, 0);
    tick(1, 0, 0, 0);
    check_state("halt_m", 2'd1, 1'b0);
    bus.m_stat = 3'd1; bus.W_stat = 3'd2; bus.W_icode = 4'h0;
    #1;
    check_ctrl("halt_w", 0, 0, 0, 0, 1, 1, 0);
    check_state("halt_w", 2'd1, 1'b0);
    tick(1, 0, 0, 1);
    check_state("halted", 2'd2, 1'b1);
    check("halted.cycle_cnt", bus.cycle_cnt, 32'd100);

    // in HALTED outputs are forced and counters frozen
    set_idle();
    bus.E_icode = 4'h5; bus.E_dstM = 4'h3; bus.d_srcA = 4'h3;
    bus.W_icode = 4'h6; bus.W_stat = 3'd1;
    #1;
    check_ctrl("halted_force", 1, 1, 0, 0, 1, 1, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    check_state("halted_hold", 2'd2, 1'b1);

    // reset recovery
    rst = 1'b1;
    #1;
    check_ctrl("rst_halted", 0, 0, 0, 0, 0, 0, 0);
    check("rst_halted.halted", {31'd0, bus.halted}, 32'd0);
    exp_cyc = 0; exp_stall = 0; exp_bub = 0; exp_ret = 0;
    tick(0, 0, 0, 0);
    check_state("after_rst", 2'd0, 1'b0);
    rst = 1'b0;
    set_idle();
    tick(1, 0, 0, 0);

    // exc_m and exc_w together: straight to HALTED, ADR does not retire
    bus.m_stat = 3'd4; bus.W_stat = 3'd3;
    #1;
    check_ctrl("both_exc", 0, 0, 0, 0, 1, 1, 0);
    tick(1, 0, 0, 0);
    check_state("both_exc", 2'd2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
